fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of decode. It owns the architectural fetch PC and issues in-order requests to an instruction memory over a valid/ready request channel with a variable-latency response channel. Fetched words are buffered in a small prefetch queue and handed to decode over a valid/ready interface. Redirects from execute and traps squash all queued and in-flight fetches.

---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel plus the
// decode handoff. The fetch unit is the master; memory and decode form the slave side.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_error;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_ir;
  logic        id_error;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_error,
    output id_valid, id_pc, id_ir, id_error,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_error,
    input  id_valid, id_pc, id_ir, id_error,
    output id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited in-order memory
// requests and buffers responses in a small prefetch queue feeding decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  input  logic         trap,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] NOP_IR = 32'h0000_0013;

  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   mis_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] discard;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          mis_pend;
  logic          halted;

  logic [31:0]   q_pc  [DEPTH];
  logic [31:0]   q_ir  [DEPTH];
  logic          q_err [DEPTH];

  logic          flush;
  logic          mis_redirect;
  logic [31:0]   flush_pc;
  logic [CW:0]   inflight;
  logic          credit_ok;
  logic          req_valid;
  logic          req_fire;
  logic          drop;
  logic          rsp_push;
  logic          mis_push;
  logic          push;
  logic          id_valid;
  logic          pop;
  logic [CW-1:0] outstanding_nxt;
  logic [31:0]   push_pc;
  logic [31:0]   push_ir;
  logic          push_err;

  assign flush        = trap | redirect;
  assign mis_redirect = redirect & ~trap & (redirect_pc[1:0] != 2'b00);
  assign flush_pc     = trap ? TRAP_PC : redirect_pc;

  // Occupancy plus in-flight requests may never exceed the queue size, so every
  // response that comes back always has a slot waiting for it.
  assign inflight  = (CW+1)'(outstanding) + (CW+1)'(occupancy);
  assign credit_ok = inflight < (CW+1)'(DEPTH);
  assign req_valid = ~reset & ~flush & ~mis_pend & ~halted & credit_ok;
  assign req_fire  = req_valid & bus.imem_req_ready;

  assign drop     = bus.imem_rsp_valid & (discard != '0);
  assign rsp_push = bus.imem_rsp_valid & ~drop & ~flush;
  // discard==0 after a misaligned redirect implies nothing is left in flight.
  assign mis_push = mis_pend & (discard == '0) & (occupancy == '0) & ~flush;
  assign push     = rsp_push | mis_push;

  assign id_valid = ~reset & (occupancy != '0) & ~flush;
  assign pop      = id_valid & bus.id_ready;

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);

  assign push_pc  = mis_push ? mis_pc : rsp_pc;
  assign push_ir  = mis_push ? NOP_IR : bus.imem_rsp_data;
  assign push_err = mis_push | bus.imem_rsp_error;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = {pc[31:2], 2'b00};
  assign bus.id_valid       = id_valid;
  assign bus.id_pc          = q_pc[rd_ptr];
  assign bus.id_ir          = q_ir[rd_ptr];
  assign bus.id_error       = q_err[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      occupancy   <= '0;
      discard     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mis_pend    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      if (flush) begin
        // Everything still in flight belongs to the squashed stream.
        pc        <= flush_pc;
        rsp_pc    <= flush_pc;
        occupancy <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        discard   <= outstanding_nxt;
        mis_pend  <= mis_redirect;
        halted    <= mis_redirect;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (drop)     discard <= discard - CW'(1);
        if (rsp_push) rsp_pc <= rsp_pc + 32'd4;
        if (push)     wr_ptr <= wr_ptr + AW'(1);
        if (pop)      rd_ptr <= rd_ptr + AW'(1);
        if (mis_push) mis_pend <= 1'b0;
        occupancy <= occupancy + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]  <= push_pc;
      q_ir[wr_ptr]  <= push_ir;
      q_err[wr_ptr] <= push_err;
    end
    if (redirect & ~trap) mis_pc <= redirect_pc;
  end

  a_outstanding_bound: assert property (@(posedge clk) disable iff (reset)
    outstanding <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: variable-latency memory model plus a decode-side
// scoreboard of expected {pc, ir, error} entries.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0080;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        err;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        trap;

  fetch_unit_if ifc ();

  fetch_unit #(.RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .trap(trap), .bus(ifc)
  );

  int          checks = 0;
  int          failures = 0;
  ent_t        sb[$];
  ent_t        mon_e;
  int          cyc = 0;
  int          mem_lat = 1;
  logic [31:0] err_addr = 32'h8;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] mem_a;
  int          req_total = 0;
  int          pop_total = 0;
  int          stale_cnt = 0;
  bit          saw_200 = 0;
  int          n, r0, p0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_run(input logic [31:0] start, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic [31:0] a;
      a = start + 32'(4 * i);
      sb.push_back('{pc: a, ir: mem_word(a), err: (a == err_addr)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      if (ifc.id_valid) break;
      cnt++;
    end
  endtask

  // Memory model: request recorded mid-cycle before its accepting edge, answered
  // mem_lat cycles later, strictly in order; reset together with the DUT.
  always @(negedge clk) begin
    if (!reset && ifc.imem_req_valid && ifc.imem_req_ready) begin
      pend_addr.push_back(ifc.imem_req_addr);
      pend_due.push_back(cyc + mem_lat);
      req_total++;
      if (ifc.imem_req_addr == 32'h200) saw_200 = 1'b1;
    end
  end

  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (reset) begin
      pend_addr.delete();
      pend_due.delete();
      ifc.imem_rsp_valid = 1'b0;
      ifc.imem_rsp_data  = '0;
      ifc.imem_rsp_error = 1'b0;
    end else if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      mem_a = pend_addr.pop_front();
      pend_due.delete(0);
      ifc.imem_rsp_valid = 1'b1;
      ifc.imem_rsp_data  = mem_word(mem_a);
      ifc.imem_rsp_error = (mem_a == err_addr);
      if (mem_a < 32'h100 || mem_a >= 32'h200) stale_cnt++;
    end else begin
      ifc.imem_rsp_valid = 1'b0;
      ifc.imem_rsp_data  = '0;
      ifc.imem_rsp_error = 1'b0;
    end
  end

  // Decode side: every accepted entry is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!reset && ifc.id_valid && ifc.id_ready) begin
      pop_total++;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("id_pc", ifc.id_pc, mon_e.pc);
        check("id_ir", ifc.id_ir, mon_e.ir);
        check("id_error", 32'(ifc.id_error), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; trap = 1'b0; redirect_pc = '0;
    ifc.id_ready = 1'b1; ifc.imem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    check("reset_id_valid", 32'(ifc.id_valid), 32'd0);

    // Free run from reset, 1-cycle memory; 0x008 returns a bus error.
    tick();
    sb.delete(); expect_run(RESET_PC, 64);
    req_total = 0; pop_total = 0;
    reset = 1'b0;
    wait_valid(n);
    check("reset_latency", 32'(n), 32'd2);
    n = 0;
    repeat (20) begin @(negedge clk); if (!ifc.id_valid) n++; end
    check("b2b_gaps", 32'(n), 32'd0);

    // Decode stall: queue fills to DEPTH and requests stop.
    tick(); ifc.id_ready = 1'b0;
    repeat (9) tick();
    @(negedge clk);
    check("stall_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    check("stall_id_valid", 32'(ifc.id_valid), 32'd1);
    check("stall_buffered", 32'(req_total - pop_total), 32'(DEPTH));
    check("stall_outstanding", 32'(pend_addr.size()), 32'd0);
    tick(); ifc.id_ready = 1'b1;
    repeat (6) tick();

    // 3-cycle memory, redirect to 0x100 with requests in flight.
    mem_lat = 3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pend_addr.size() >= 2) break;
    end
    check("pend_before_redirect", 32'(pend_addr.size() >= 2), 32'd1);
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    sb.delete(); expect_run(32'h100, 40);
    stale_cnt = 0; p0 = pop_total;
    tick(); redirect = 1'b0;
    repeat (8) tick();
    check("stale_dropped", 32'(stale_cnt >= 2), 32'd1);
    mem_lat = 1;
    repeat (8) tick();
    check("redirect_stream_popped", 32'(pop_total - p0 >= 4), 32'd1);

    // Trap and redirect together: trap wins, 0x200 never fetched.
    tick();
    trap = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    sb.delete(); expect_run(TRAP_PC, 40);
    saw_200 = 1'b0;
    @(negedge clk);
    check("flush_id_valid", 32'(ifc.id_valid), 32'd0);
    check("flush_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    tick(); trap = 1'b0; redirect = 1'b0;
    wait_valid(n);
    check("trap_latency", 32'(n), 32'd2);
    repeat (10) tick();
    check("no_fetch_200", 32'(saw_200), 32'd0);

    // Misaligned redirect: one faulting NOP entry, then fetch halts.
    tick();
    redirect = 1'b1; redirect_pc = 32'h102;
    sb.delete(); sb.push_back('{pc: 32'h102, ir: 32'h0000_0013, err: 1'b1});
    r0 = req_total; p0 = pop_total;
    tick(); redirect = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    check("mis_no_req", 32'(req_total - r0), 32'd0);
    check("mis_one_entry", 32'(pop_total - p0), 32'd1);
    check("mis_halt_id_valid", 32'(ifc.id_valid), 32'd0);
    check("mis_halt_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    tick();
    redirect = 1'b1; redirect_pc = 32'h300;
    sb.delete(); expect_run(32'h300, 40);
    p0 = pop_total;
    tick(); redirect = 1'b0;
    repeat (10) tick();
    check("resume_300_popped", 32'(pop_total - p0 >= 4), 32'd1);

    // Reset mid-stream with a slow memory.
    mem_lat = 3;
    repeat (5) tick();
    reset = 1'b1; sb.delete();
    @(negedge clk);
    check("midreset_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    check("midreset_id_valid", 32'(ifc.id_valid), 32'd0);
    tick();
    expect_run(RESET_PC, 40);
    req_total = 0; pop_total = 0;
    reset = 1'b0;
    wait_valid(n);
    check("midreset_latency", 32'(n), 32'd4);
    repeat (15) tick();
    check("midreset_popped", 32'(pop_total >= 4), 32'd1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
